// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Optional statistics are built only when FIFO_WR_ARB_STATS_EN is defined.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_IDX_W   = $clog2(DEF_NUM_REQ);

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-port bundle for fifo_wr_arbiter.
// master = arbiter side, slave = requesters/FIFO side.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      fifo_almostfull;
    logic                      wr_en;
    logic [DATA_W-1:0]         wr_data;
    logic [$clog2(NUM_REQ)-1:0] grant_id;
    logic                      busy;

    modport master (
        input  req_valid, req_data, req_last,
        input  fifo_full, fifo_almostfull,
        output req_ready, wr_en, wr_data,
        output grant_id, busy
    );

    modport slave (
        output req_valid, req_data, req_last,
        output fifo_full, fifo_almostfull,
        input  req_ready, wr_en, wr_data,
        input  grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin search: first valid requester at or above ptr_i,
// wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [IW-1:0]      pick_o,
    output logic               any_o
);

    function automatic logic [IW-1:0] wrap(
        input logic [IW-1:0] p,
        input int            k
    );
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IW'(s);
    endfunction

    // Walk offsets from far to near so the nearest hit is kept.
    always_comb begin
        pick_o = '0;
        any_o  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid_i[wrap(ptr_i, k)]) begin
                pick_o = wrap(ptr_i, k);
                any_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for a FIFO write port, registered output.
// Define FIFO_WR_ARB_STATS_EN for per-requester word counters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    fifo_wr_arbiter_if.master          bus
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    input  logic [$clog2(NUM_REQ)-1:0] stat_sel,
    input  logic                       stat_clr,
    output logic [15:0]                stat_count
`endif
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [0:0] S_ARB   = ARB;
    localparam logic [0:0] S_BURST = BURST;

    logic [0:0]         state_q, state_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [IW-1:0]      gnt_q, gnt_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic               wr_en_q, wr_en_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;

    logic [IW-1:0]      pick, idx;
    logic               any, can_write, xfer;
    logic [NUM_REQ-1:0] ready;

    function automatic logic [IW-1:0] inc(input logic [IW-1:0] v);
        return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
    endfunction

    rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid_i (bus.req_valid),
        .ptr_i   (rr_q),
        .pick_o  (pick),
        .any_o   (any)
    );

    // The registered write still in flight may be the one that fills the FIFO.
    always_comb begin
        can_write = !bus.fifo_full && !(wr_en_q && bus.fifo_almostfull);
        idx = (state_q == S_BURST) ? gnt_q : pick;
        ready = '0;
        if (state_q == S_BURST) ready[gnt_q] = can_write;
        else                    ready[pick]  = can_write && any;
        xfer = bus.req_valid[idx] && ready[idx];
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gnt_d     = gnt_q;
        beat_d    = beat_q;
        wr_en_d   = xfer;
        wr_data_d = wr_data_q;
        if (xfer) begin
            wr_data_d = bus.req_data[int'(idx)*DATA_W +: DATA_W];
            if (state_q == S_ARB) begin
                gnt_d = pick;
                if (bus.req_last[pick] || MAX_BURST == 1) begin
                    rr_d = inc(pick);
                end else begin
                    state_d = S_BURST;
                    beat_d  = BW'(1);
                end
            end else begin
                beat_d = beat_q + 1'b1;
                if (bus.req_last[gnt_q] ||
                    beat_q == BW'(MAX_BURST - 1)) begin
                    state_d = S_ARB;
                    rr_d    = inc(gnt_q);
                    beat_d  = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_ARB;
            rr_q      <= '0;
            gnt_q     <= '0;
            beat_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            beat_q    <= beat_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.req_ready = rst ? ready : '0;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.grant_id  = gnt_q;
    assign bus.busy      = (state_q == S_BURST);

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else if (stat_clr) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else if (xfer && cnt_q[idx] != 16'hFFFF) begin
            cnt_q[idx] <= cnt_q[idx] + 16'd1;
        end
    end

    assign stat_count = cnt_q[stat_sel];
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
    logic [1:0]  stat_sel;
    logic        stat_clr;
    logic [15:0] stat_count;
`endif

    fifo_wr_arbiter #(
        .NUM_REQ   (NR),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stat_sel   (stat_sel),
        .stat_clr   (stat_clr),
        .stat_count (stat_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v,
                           input logic [7:0] d, input logic l);
        bus.req_valid[i]        = v;
        bus.req_data[i*DW +: DW] = d;
        bus.req_last[i]         = l;
    endtask

    int w3[7]  = '{0, 1, 2, 3, 4, 4, 5};
    int r3[7]  = '{2, 2, 2, 2, 4, 2, 2};
    int d3[7]  = '{'h10, 'h11, 'h12, 'h13, 'h20, 'h14, 'h15};
    int b3[7]  = '{1, 1, 1, 0, 0, 1, 0};
    int g3[7]  = '{1, 1, 1, 1, 2, 1, 1};

    int w4[6]  = '{0, 1, 1, 1, 2, 2};
    int f4[6]  = '{0, 0, 1, 0, 1, 0};
    int a4[6]  = '{0, 1, 0, 1, 0, 0};
    int r4[6]  = '{8, 0, 0, 8, 0, 8};
    int e4[6]  = '{1, 0, 0, 1, 0, 1};
    int d4[6]  = '{'h30, 'h30, 'h30, 'h31, 'h31, 'h32};
    int b4[6]  = '{1, 1, 1, 1, 1, 0};

    initial begin
        bus.req_valid       = '0;
        bus.req_data        = '0;
        bus.req_last        = '0;
        bus.fifo_full       = 1'b0;
        bus.fifo_almostfull = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
        stat_sel = '0;
        stat_clr = 1'b0;
`endif
        // reset state
        #12;
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_grant", bus.grant_id, 0);
        chk("rst_busy", bus.busy, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // idle
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_wr_en", bus.wr_en, 0);
            chk("idle_ready", bus.req_ready, 0);
            chk("idle_grant", bus.grant_id, 0);
            chk("idle_busy", bus.busy, 0);
        end

        // rotation with single-word packets
        for (int k = 0; k < NR; k++) set_req(k, 1'b1, 8'hA0 + 8'(k), 1'b1);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("rot_ready", bus.req_ready, 1 << (c % 4));
            tick();
            chk("rot_wr_en", bus.wr_en, 1);
            chk("rot_wr_data", bus.wr_data, 'hA0 + (c % 4));
            chk("rot_grant", bus.grant_id, c % 4);
        end
        bus.req_valid = '0;
        #1;
        chk("rot_idle_ready", bus.req_ready, 0);
        tick();
        chk("rot_idle_wr_en", bus.wr_en, 0);
        chk("rot_hold_data", bus.wr_data, 'hA0);

        // 6-word packet from 1 split by MAX_BURST, 2 served in between
        for (int c = 0; c < 7; c++) begin
            set_req(1, 1'b1, 8'h10 + 8'(w3[c]), w3[c] == 5);
            set_req(2, c < 5, 8'h20, 1'b1);
            #1;
            chk("burst_ready", bus.req_ready, r3[c]);
            tick();
            chk("burst_wr_en", bus.wr_en, 1);
            chk("burst_wr_data", bus.wr_data, d3[c]);
            chk("burst_busy", bus.busy, b3[c]);
            chk("burst_grant", bus.grant_id, g3[c]);
        end
        bus.req_valid = '0;
        tick();

        // full / almostfull stall of a burst from requester 3
        for (int c = 0; c < 6; c++) begin
            bus.fifo_full       = f4[c][0];
            bus.fifo_almostfull = a4[c][0];
            set_req(3, 1'b1, 8'h30 + 8'(w4[c]), w4[c] == 2);
            #1;
            chk("full_ready", bus.req_ready, r4[c]);
            tick();
            chk("full_wr_en", bus.wr_en, e4[c]);
            chk("full_wr_data", bus.wr_data, d4[c]);
            chk("full_busy", bus.busy, b4[c]);
        end
        bus.req_valid       = '0;
        bus.fifo_full       = 1'b0;
        bus.fifo_almostfull = 1'b0;
        tick();

        // reset mid-burst
        set_req(1, 1'b1, 8'h50, 1'b1);
        #1;
        chk("pre_rst_ready1", bus.req_ready, 'b0010);
        tick();
        chk("pre_rst_data1", bus.wr_data, 'h50);
        set_req(1, 1'b0, 8'h00, 1'b0);
        set_req(2, 1'b1, 8'h40, 1'b0);
        #1;
        chk("pre_rst_ready2", bus.req_ready, 'b0100);
        tick();
        chk("pre_rst_busy", bus.busy, 1);
        set_req(2, 1'b1, 8'h41, 1'b0);
        #1;
        chk("pre_rst_ready3", bus.req_ready, 'b0100);
        tick();
        chk("pre_rst_data2", bus.wr_data, 'h41);
        chk("pre_rst_grant", bus.grant_id, 2);
        set_req(2, 1'b1, 8'h42, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_rst_wr_en", bus.wr_en, 0);
        chk("mid_rst_wr_data", bus.wr_data, 0);
        chk("mid_rst_grant", bus.grant_id, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_ready", bus.req_ready, 0);
        tick();
        rst = 1'b1;
        set_req(0, 1'b1, 8'h60, 1'b1);
        set_req(1, 1'b1, 8'h61, 1'b1);
        set_req(2, 1'b1, 8'h42, 1'b1);
        #1;
        chk("post_rst_ready", bus.req_ready, 'b0001);
        tick();
        chk("post_rst_data", bus.wr_data, 'h60);
        chk("post_rst_grant", bus.grant_id, 0);
        chk("post_rst_busy", bus.busy, 0);
        bus.req_valid = '0;

        // five single words from requester 2
        for (int n = 0; n < 5; n++) begin
            set_req(2, 1'b1, 8'h70 + 8'(n), 1'b1);
            #1;
            chk("r2_ready", bus.req_ready, 'b0100);
            tick();
            chk("r2_wr_data", bus.wr_data, 'h70 + n);
        end
        bus.req_valid = '0;
        tick();

`ifdef FIFO_WR_ARB_STATS_EN
        stat_sel = 2'd2;
        #1 chk("stat_r2", stat_count, 5);
        stat_sel = 2'd0;
        #1 chk("stat_r0", stat_count, 1);
        stat_sel = 2'd1;
        #1 chk("stat_r1", stat_count, 0);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        stat_sel = 2'd2;
        #1 chk("stat_clr", stat_count, 0);
        set_req(2, 1'b1, 8'h80, 1'b1);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        bus.req_valid = '0;
        #1 chk("stat_clr_wins", stat_count, 0);
        set_req(2, 1'b1, 8'h81, 1'b1);
        tick();
        bus.req_valid = '0;
        #1 chk("stat_after_clr", stat_count, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the team's 8-bit synchronous FIFO between NUM_REQ requesters. Supports packet bursts: the winner keeps the port until it marks the last word or MAX_BURST words are sent. Uses the FIFO's full and almostfull flags so the FIFO is never overrun. Sits directly in front of the FIFO write port. wr_en and wr_data are registered.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, word width; matches the FIFO data width
MAX_BURST, 4, maximum words per grant (1..16)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester word available
req_data  in  NUM_REQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  final word of packet
req_ready  out  NUM_REQ  per-requester accept (combinational)
fifo_full  in  1  FIFO full flag
fifo_almostfull  in  1  FIFO occupancy == DEPTH-1
wr_en  out  1  FIFO write enable (registered)
wr_data  out  DATA_W  FIFO write data (registered)
grant_id  out  $clog2(NUM_REQ)  current or last owner
busy  out  1  high in BURST state

Behaviour:
- Reset (rst low, asynchronous): state=ARB, rr_ptr=0, beat_cnt=0, wr_en=0, wr_data=0, grant_id=0, req_ready=0. Reset mid-burst drops the burst; words already written stay in the FIFO.
- can_write = !fifo_full && !(wr_en && fifo_almostfull). This accounts for the one in-flight registered write.
- Transfer on requester i = req_valid[i] && req_ready[i]. On the next edge: wr_en=1 and wr_data=req_data[i]. Otherwise wr_en=0 and wr_data holds its value. Latency is 1 cycle.
- ARB state:
  - pick = first i with req_valid[i], searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - If can_write and any valid: req_ready[pick]=1, all others 0, grant_id<=pick.
  - If req_last[pick] or MAX_BURST==1: stay in ARB, rr_ptr<=pick+1 (wrap).
  - Else: owner<=pick, beat_cnt<=1, go to BURST.
  - No valid request or !can_write: req_ready=0, no state change.
- BURST state:
  - req_ready[owner]=can_write; all others 0.
  - On transfer: beat_cnt++. If req_last[owner] or beat_cnt==MAX_BURST-1, go to ARB and set rr_ptr<=owner+1 (wrap).
  - If the owner deasserts valid, the lock holds and the arbiter waits. No other requester is served.
- FIFO full mid-burst: the burst stalls and resumes when can_write returns. Beat count is preserved.
- All requesters valid continuously: grants rotate in order 0,1,2,3,0,...
- Requester data must stay stable while valid && !ready.

Optional Feature:
Macro: FIFO_WR_ARB_STATS_EN.
- Defined: adds ports stat_sel (in, $clog2(NUM_REQ)), stat_clr (in, 1) and stat_count (out, 16).
  - One 16-bit saturating counter per requester counts transferred words.
  - stat_count = counter[stat_sel], combinational.
  - stat_clr zeroes all counters synchronously; clear wins over a same-cycle increment.
  - Counters reset to 0.
- Undefined: no counters and no extra ports. Arbitration behaviour is identical.

Decomposition:
- Package fifo_arb_pkg: state enum {ARB, BURST}, DATA_W default, clog2-width helper constant.
- One sub-module rr_picker: combinational search over (valid vector, rr_ptr) returning the pick index and an any-valid flag.
- The top holds the FSM, registers and optional counters.

Test Plan:
- Reset then idle, no valid requests: wr_en=0, req_ready=0, grant_id=0, busy=0 for 10 cycles.
- Requesters 0–3 valid continuously, each word with req_last=1: wr_data sequence shows owners 0,1,2,3,0; each word appears one cycle after its req_ready.
- Requester 1 sends a 6-word packet (last on word 6) with MAX_BURST=4: words 1–4 go out back-to-back, requester 2 is served next, then requester 1 sends the remaining 2 words.
- FIFO reaches occupancy 15 of 16 with almostfull=1 and wr_en=1: req_ready drops the same cycle; after a FIFO read, the pending burst resumes; no write occurs while full.
- rst pulsed low mid-burst (beat_cnt=2): outputs clear immediately; after release, arbitration restarts from requester 0.
- With FIFO_WR_ARB_STATS_EN: 5 words from requester 2, then stat_sel=2 gives stat_count=5; stat_clr gives 0.
